// File: rtl/dec_entry_pkg.sv
// Shared definitions for the decimal entry unit: FSM state encoding and
// digit-related constants.
package dec_entry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_SIGN  = 2'd2,
    ST_VALID = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam int         DIGIT_CNT_W = 3;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability down-counter and
// falling-edge detector. Emits one 1-cycle press pulse per accepted
// high->low transition of the active-low key.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_0;
  logic             sync_1;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous key level into the clk domain (idle level is high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_0 <= 1'b1;
      sync_1 <= 1'b1;
    end else begin
      sync_0 <= key_n;
      sync_1 <= sync_0;
    end
  end

  // Accept a new level only after it differs from the accepted one for
  // DEBOUNCE_CYCLES consecutive cycles; pulse when the accepted level falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= CNT_LOAD;
      stable <= 1'b1;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_1 == stable) begin
        cnt <= CNT_LOAD;
      end else if (cnt == '0) begin
        stable <= sync_1;
        press  <= stable;
        cnt    <= CNT_LOAD;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/decimal_entry_unit.sv
// Decimal entry unit: collects BCD digits from switches on debounced key
// presses, converts them to a signed binary value and hands it to Control
// over a req/valid/ack handshake.
// Optional build macro DECIMAL_ENTRY_ECHO_EN drives echo_value with the
// running signed entry; without it echo_value is tied to 0.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   ST_IDLE  | waiting for req; key presses ignored
//   ST_ENTRY | collecting digits, req_led lit
//   ST_SIGN  | one cycle: apply sign_in and commit to value_out
//   ST_VALID | value_out valid, waiting for value_ack
module decimal_entry_unit
  import dec_entry_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int DIGITS          = 7,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             digit_in,
  input  logic                   sign_in,
  input  logic                   key_digit_n,
  input  logic                   key_done_n,
  input  logic                   key_clear_n,
  input  logic                   req,
  input  logic                   value_ack,
  output logic [WIDTH-1:0]       value_out,
  output logic                   value_valid,
  output logic                   req_led,
  output logic [DIGIT_CNT_W-1:0] digit_count,
  output logic                   entry_err,
  output logic [WIDTH-1:0]       echo_value
);

  localparam logic [DIGIT_CNT_W-1:0] DIGIT_LIMIT = DIGIT_CNT_W'(DIGITS);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] acc;
  logic             digit_press;
  logic             done_press;
  logic             clear_press;
  logic             acc_clr;
  logic             acc_shift;
  logic             reject;
  logic             commit;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_digit (
    .clk(clk), .rst(rst), .key_n(key_digit_n), .press(digit_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_done (
    .clk(clk), .rst(rst), .key_n(key_done_n), .press(done_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clear (
    .clk(clk), .rst(rst), .key_n(key_clear_n), .press(clear_press)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state and datapath strobes; abort on req loss beats any key, and
  // among keys clear beats done beats digit.
  always_comb begin
    state_next = state;
    acc_clr    = 1'b0;
    acc_shift  = 1'b0;
    reject     = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          state_next = ST_ENTRY;
          acc_clr    = 1'b1;
        end
      end
      ST_ENTRY: begin
        if (!req) begin
          state_next = ST_IDLE;
          acc_clr    = 1'b1;
        end else if (clear_press) begin
          acc_clr = 1'b1;
        end else if (done_press) begin
          state_next = ST_SIGN;
        end else if (digit_press) begin
          if (digit_in > BCD_MAX || digit_count == DIGIT_LIMIT) reject = 1'b1;
          else                                                  acc_shift = 1'b1;
        end
      end
      ST_SIGN: begin
        if (!req) begin
          state_next = ST_IDLE;
          acc_clr    = 1'b1;
        end else begin
          commit     = 1'b1;
          state_next = ST_VALID;
        end
      end
      ST_VALID: begin
        if (value_ack) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Accumulator, digit counter, committed value and reject pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      digit_count <= '0;
      value_out   <= '0;
      entry_err   <= 1'b0;
    end else begin
      entry_err <= reject;
      if (acc_clr) begin
        acc         <= '0;
        digit_count <= '0;
      end else if (acc_shift) begin
        acc         <= (acc << 3) + (acc << 1) + WIDTH'(digit_in);
        digit_count <= digit_count + 1'b1;
      end
      // Two's complement negation of zero is zero, so -0 commits as 0.
      if (commit) value_out <= sign_in ? (~acc + 1'b1) : acc;
    end
  end

  assign value_valid = (state == ST_VALID);
  assign req_led     = (state == ST_ENTRY);

`ifdef DECIMAL_ENTRY_ECHO_EN
  logic [WIDTH-1:0] acc_signed;

  // Live signed view of the entry for the display path.
  always_comb begin
    acc_signed = sign_in ? (~acc + 1'b1) : acc;
    echo_value = '0;
    if (state == ST_ENTRY)      echo_value = acc_signed;
    else if (state == ST_VALID) echo_value = value_out;
  end
`else
  assign echo_value = '0;
`endif

endmodule

// File: tb/tb_decimal_entry_unit.sv
// Directed self-checking bench for decimal_entry_unit (DEBOUNCE_CYCLES=4).
module tb_decimal_entry_unit;
  import dec_entry_pkg::*;

  localparam int WIDTH = 32;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [3:0]             digit_in = 4'd0;
  logic                   sign_in = 1'b0;
  logic                   key_digit_n = 1'b1;
  logic                   key_done_n = 1'b1;
  logic                   key_clear_n = 1'b1;
  logic                   req = 1'b0;
  logic                   value_ack = 1'b0;
  logic [WIDTH-1:0]       value_out;
  logic                   value_valid;
  logic                   req_led;
  logic [DIGIT_CNT_W-1:0] digit_count;
  logic                   entry_err;
  logic [WIDTH-1:0]       echo_value;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int err_pulses = 0;
  int valid_rises = 0;
  int led_fall_cyc = 0;
  int valid_rise_cyc = 0;
  logic prev_led = 1'b0;
  logic prev_valid = 1'b0;

  decimal_entry_unit #(.WIDTH(WIDTH), .DIGITS(7), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .sign_in(sign_in),
    .key_digit_n(key_digit_n), .key_done_n(key_done_n), .key_clear_n(key_clear_n),
    .req(req), .value_ack(value_ack), .value_out(value_out),
    .value_valid(value_valid), .req_led(req_led), .digit_count(digit_count),
    .entry_err(entry_err), .echo_value(echo_value)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (entry_err) err_pulses++;
    if (prev_led && !req_led) led_fall_cyc = cyc;
    if (!prev_valid && value_valid) begin
      valid_rise_cyc = cyc;
      valid_rises++;
    end
    prev_led   = req_led;
    prev_valid = value_valid;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // 0 = digit, 1 = done, 2 = clear, 3 = clear+done together
  task automatic press(input int k);
    case (k)
      0: key_digit_n = 1'b0;
      1: key_done_n  = 1'b0;
      2: key_clear_n = 1'b0;
      default: begin key_clear_n = 1'b0; key_done_n = 1'b0; end
    endcase
    tick(10);
    key_digit_n = 1'b1;
    key_done_n  = 1'b1;
    key_clear_n = 1'b1;
    tick(10);
  endtask

  task automatic enter_digit(input logic [3:0] d);
    digit_in = d;
    press(0);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 60 && !value_valid; i++) tick(1);
    check_val({tag, "_valid"}, {31'd0, value_valid}, 32'd1);
    check_val({tag, "_lat"}, valid_rise_cyc - led_fall_cyc, 32'd1);
  endtask

  task automatic ack_and_drop;
    value_ack = 1'b1;
    req = 1'b0;
    tick(1);
    value_ack = 1'b0;
    check_val("ack_valid_low", {31'd0, value_valid}, 32'd0);
    tick(2);
  endtask

  logic [31:0] echo_exp;
  int errs_before;
  int rises_before;

  initial begin
    tick(3);
    check_val("rst_value", value_out, 32'd0);
    check_val("rst_valid", {31'd0, value_valid}, 32'd0);
    check_val("rst_led", {31'd0, req_led}, 32'd0);
    check_val("rst_count", {29'd0, digit_count}, 32'd0);
    check_val("rst_err", {31'd0, entry_err}, 32'd0);
    check_val("rst_echo", echo_value, 32'd0);
    rst = 1'b0;
    tick(2);

    // keys ignored in IDLE
    enter_digit(4'd5);
    check_val("idle_led", {31'd0, req_led}, 32'd0);
    check_val("idle_count", {29'd0, digit_count}, 32'd0);

    // 1,2,3 positive; req dropped in VALID must hold until ack
    req = 1'b1;
    sign_in = 1'b0;
    tick(2);
    check_val("entry_led", {31'd0, req_led}, 32'd1);
    enter_digit(4'd1);
    enter_digit(4'd2);
    enter_digit(4'd3);
    check_val("cnt_123", {29'd0, digit_count}, 32'd3);
`ifdef DECIMAL_ENTRY_ECHO_EN
    echo_exp = 32'd123;
`else
    echo_exp = 32'd0;
`endif
    check_val("echo_entry", echo_value, echo_exp);
    press(1);
    wait_valid("p123");
    check_val("val_123", value_out, 32'h0000007B);
    req = 1'b0;
    tick(3);
    check_val("valid_hold_noreq", {31'd0, value_valid}, 32'd1);
    check_val("val_hold", value_out, 32'h0000007B);
    ack_and_drop();

    // -45
    req = 1'b1;
    tick(2);
    enter_digit(4'd4);
    enter_digit(4'd5);
    sign_in = 1'b1;
    press(1);
    wait_valid("n45");
    check_val("val_m45", value_out, 32'hFFFFFFD3);
    ack_and_drop();

    // digit limit
    sign_in = 1'b0;
    req = 1'b1;
    tick(2);
    errs_before = err_pulses;
    for (int d = 1; d <= 7; d++) enter_digit(4'(d));
    check_val("lim_noerr", err_pulses - errs_before, 32'd0);
    enter_digit(4'd8);
    check_val("lim_err", err_pulses - errs_before, 32'd1);
    check_val("lim_count", {29'd0, digit_count}, 32'd7);
    press(1);
    wait_valid("lim");
    check_val("val_lim", value_out, 32'd1234567);
    ack_and_drop();

    // invalid digit and glitch
    req = 1'b1;
    tick(2);
    enter_digit(4'd3);
    errs_before = err_pulses;
    enter_digit(4'hA);
    check_val("inv_err", err_pulses - errs_before, 32'd1);
    check_val("inv_count", {29'd0, digit_count}, 32'd1);
    digit_in = 4'd7;
    key_digit_n = 1'b0;
    tick(2);
    key_digit_n = 1'b1;
    tick(12);
    check_val("glitch_count", {29'd0, digit_count}, 32'd1);
    press(1);
    wait_valid("inv");
    check_val("val_inv", value_out, 32'd3);
    ack_and_drop();

    // clear then negative zero
    req = 1'b1;
    tick(2);
    enter_digit(4'd9);
    enter_digit(4'd9);
    press(2);
    check_val("clr_count", {29'd0, digit_count}, 32'd0);
    sign_in = 1'b1;
    press(1);
    wait_valid("zero");
    check_val("val_zero", value_out, 32'd0);
    ack_and_drop();

    // clear+done together stays in ENTRY; then abort
    sign_in = 1'b0;
    req = 1'b1;
    tick(2);
    enter_digit(4'd2);
    press(3);
    check_val("cd_led", {31'd0, req_led}, 32'd1);
    check_val("cd_count", {29'd0, digit_count}, 32'd0);
    check_val("cd_valid", {31'd0, value_valid}, 32'd0);
    enter_digit(4'd6);
    enter_digit(4'd7);
    check_val("abort_pre", {29'd0, digit_count}, 32'd2);
    rises_before = valid_rises;
    req = 1'b0;
    tick(20);
    check_val("abort_led", {31'd0, req_led}, 32'd0);
    check_val("abort_rises", valid_rises - rises_before, 32'd0);
    req = 1'b1;
    tick(2);
    check_val("reentry_count", {29'd0, digit_count}, 32'd0);

    // reset while VALID
    enter_digit(4'd8);
    press(1);
    wait_valid("rstv");
    check_val("val_8", value_out, 32'd8);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("arst_value", value_out, 32'd0);
    check_val("arst_valid", {31'd0, value_valid}, 32'd0);
    check_val("arst_led", {31'd0, req_led}, 32'd0);
    check_val("arst_count", {29'd0, digit_count}, 32'd0);
    check_val("arst_echo", echo_value, 32'd0);
    tick(2);
    rst = 1'b0;
    req = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
